// File: rtl/iiitb_gc_pkg.sv
// Shared types, defaults and helpers for the Gray-code counter run controller.
package iiitb_gc_pkg;

  localparam int GC_WIDTH = 8;
  localparam int GC_LEN_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Width-agnostic: unused upper Gray bits are zero, so they leave the low bits untouched.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/iiitb_gc_step_chk.sv
// Step checker: compares each gc_count sample against the previous one given last cycle's enable/clear.
// Also registers the binary position; err is sticky until err_clr, with a new violation winning.
module iiitb_gc_step_chk
  import iiitb_gc_pkg::*;
#(
  parameter int WIDTH = GC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gc_count,
  input  logic             gc_enable,
  input  logic             gc_reset,
  input  logic             err_clr,
  output logic [WIDTH-1:0] pos_bin,
  output logic             err
);

  logic [WIDTH-1:0] prev_g;
  logic [WIDTH-1:0] cur_bin;
  logic             prev_en;
  logic             prev_rst;
  logic             armed;
  logic             viol;

  assign cur_bin = WIDTH'(gray2bin(32'(gc_count)));

  // pos_bin holds the previous sample in binary, so it doubles as the increment reference.
  always_comb begin
    viol = 1'b0;
    if (armed) begin
      if (prev_rst)     viol = (gc_count != '0);
      else if (prev_en) viol = (cur_bin != pos_bin + WIDTH'(1));
      else              viol = (gc_count != prev_g);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_g   <= '0;
      prev_en  <= 1'b0;
      prev_rst <= 1'b0;
      armed    <= 1'b0;
      pos_bin  <= '0;
      err      <= 1'b0;
    end else begin
      prev_g   <= gc_count;
      prev_en  <= gc_enable;
      prev_rst <= gc_reset;
      armed    <= 1'b1;
      pos_bin  <= cur_bin;
      if (viol)         err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: rtl/iiitb_gc_ctrl.sv
// Run controller: accepts a command in IDLE, optionally clears the counter, then enables it for
// cmd_len unpaused cycles; pulses done (with aborted) at the end of every accepted command.
module iiitb_gc_ctrl
  import iiitb_gc_pkg::*;
#(
  parameter int WIDTH = GC_WIDTH,
  parameter int LEN_W = GC_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_clear,
  input  logic             pause,
  input  logic             abort,
  output logic             gc_enable,
  output logic             gc_reset,
  input  logic [WIDTH-1:0] gc_count,
  output logic [WIDTH-1:0] pos_bin,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  input  logic             err_clr
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] remaining, rem_nxt, rem_src;
  logic             en_nxt;
  logic             abt_nxt;
  logic             run_step;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign gc_reset  = (state == ST_CLEAR);
  assign done      = (state == ST_DONE);

  // run_step grants one enable cycle (or finishes) from whichever state hands over to RUN.
  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    rem_src   = remaining;
    en_nxt    = 1'b0;
    abt_nxt   = 1'b0;
    run_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          rem_src = cmd_len;
          rem_nxt = cmd_len;
          if (cmd_clear) state_nxt = ST_CLEAR;
          else           run_step  = 1'b1;
        end
      end
      ST_CLEAR, ST_RUN: begin
        if (abort) begin
          state_nxt = ST_DONE;
          abt_nxt   = 1'b1;
        end else begin
          run_step = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (run_step) begin
      if (rem_src == '0) begin
        state_nxt = ST_DONE;
      end else begin
        state_nxt = ST_RUN;
        if (!pause) begin
          en_nxt  = 1'b1;
          rem_nxt = rem_src - LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      gc_enable <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      gc_enable <= en_nxt;
      aborted   <= abt_nxt;
    end
  end

  iiitb_gc_step_chk #(.WIDTH(WIDTH)) u_step_chk (
    .clk       (clk),
    .reset     (reset),
    .gc_count  (gc_count),
    .gc_enable (gc_enable),
    .gc_reset  (gc_reset),
    .err_clr   (err_clr),
    .pos_bin   (pos_bin),
    .err       (err)
  );

endmodule

// File: doc/iiitb_gc_ctrl.md
# iiitb_gc_ctrl

Run controller for the 8-bit Gray-code counter. It accepts run commands over a valid/ready handshake and drives the counter's enable, plus an optional clear, for exactly the commanded number of cycles. It monitors the counter output for illegal steps and reports completion, abort and error status. It sits between the host/sequencer logic and the counter instance.

## Interface
- WIDTH, 8, Gray counter width
- LEN_W, 16, width of the run-length field
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller idle and able to accept
- cmd_len  in  LEN_W  number of counter enable cycles; 0 means no-op
- cmd_clear  in  1  clear the counter before running
- pause  in  1  hold gc_enable low while set; run length is not consumed
- abort  in  1  terminate the current run
- gc_enable  out  1  to counter enable
- gc_reset  out  1  one-cycle clear pulse to the counter reset
- gc_count  in  WIDTH  counter Gray output
- pos_bin  out  WIDTH  registered binary equivalent of gc_count
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of every accepted command
- aborted  out  1  valid with done; run ended by abort
- err  out  1  sticky step-violation flag
- err_clr  in  1  clears err

## Operation
- FSM states are IDLE, CLEAR, RUN and DONE. The reset state is IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_len into the counter `remaining` and latch cmd_clear.
  - Next state: CLEAR if cmd_clear; otherwise DONE if len==0; otherwise RUN.
- CLEAR:
  - gc_reset=1 for exactly one cycle.
  - Next state: DONE if len==0, otherwise RUN.
  - abort here goes to DONE with aborted=1.
- RUN:
  - gc_enable=1 whenever pause=0. Each enabled cycle decrements `remaining`.
  - When an enabled cycle has remaining==1, the next state is DONE.
  - abort has priority over enable: gc_enable=0 that cycle, next state DONE, aborted=1.
- DONE:
  - done=1. aborted reflects whether the run was aborted.
  - Next state: IDLE.
- Commands presented while busy are not accepted and remain pending.
- Step checker:
  - Samples gc_count every cycle and compares it with the previous sample, using the gc_enable/gc_reset value from the previous cycle.
  - Previous gc_reset=1: gc_count must equal 0.
  - Previous gc_enable=1: the binary value must equal the previous value + 1 mod 2^WIDTH. Wrap 0x80→0x00 is legal.
  - Otherwise gc_count must be unchanged.
  - Any violation sets err. If err_clr and a violation occur in the same cycle, set wins.
  - The checker is inactive in the first cycle after reset deassertion.
- Gray-to-binary conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].

## Timing
- Reset values:
  - state=IDLE, so cmd_ready=1.
  - gc_enable, gc_reset, busy, done, aborted and err are 0.
  - pos_bin and remaining are 0.
- All outputs are registered or decoded from the state register. There are no combinational paths from input to output except cmd_ready, which is decoded from state only.
- Command accepted at edge N, no clear, no pause:
  - gc_enable is high for cycles N+1 … N+len.
  - done is high in cycle N+len+1.
  - cmd_ready is high again in cycle N+len+2.
- cmd_clear adds one cycle: gc_reset is high in N+1 and enable starts at N+2.
- len==0: done is high in N+1. With clear, done is high in N+2.
- Each pause cycle extends the run by one cycle.
- pos_bin lags gc_count by one cycle.
- Asynchronous reset mid-run:
  - Immediately returns to IDLE and drops gc_enable.
  - No done pulse is generated for the interrupted command.
  - err is cleared.
- The counter is assumed to update on the edge that samples gc_enable=1.

## Structure
- A shared package (iiitb_gc_pkg) holds:
  - the state enum;
  - the WIDTH and LEN_W defaults;
  - a gray2bin function.
- One sub-module, iiitb_gc_step_chk, contains:
  - the previous-sample registers;
  - the conversion and increment comparison;
  - the sticky err logic.
- The top level contains the FSM, the `remaining` counter and the handshake.

## Test plan
- Reset, then cmd_len=5 with clear=0: gc_enable is high for exactly 5 cycles, gc_count goes 00→01→03→02→06→07, done pulses once, err stays 0.
- cmd_len=300 with cmd_clear=1: gc_reset is pulsed once, then 300 enabled cycles. The counter wraps through 0x80→0x00 with no err, and the final pos_bin is 300 mod 256 = 44.
- cmd_len=10 with pause held for 3 cycles mid-run: gc_enable is high for 10 cycles in total, and done arrives 3 cycles later than in the unpaused run.
- abort asserted on the 4th cycle of a 20-cycle run: gc_enable is low from that cycle, done=1 and aborted=1 next cycle, and the counter holds at Gray 0x02.
- Model forces gc_count to jump by two bits: err is set and remains set; err_clr clears it. cmd_len=0: done pulses in the cycle after acceptance with no gc_enable.
- Async reset asserted during RUN: gc_enable drops without a clock edge, no done pulse occurs, and cmd_ready=1 after release.
